// File: rtl/shared_bus_memory_port.sv
// ---------------------------------------------------------------------------
// shared_bus_memory_port
//
// This is the memory-side end of the shared client data bus. It combines two
// functions:
//   * A round-robin arbiter for NUM_CLIENTS requesters. The arbiter inserts a
//     turnaround dead cycle between owners. HOLD_LIMIT optionally caps how
//     long one owner can keep the bus.
//   * A byte-addressed, little-endian RAM window of DEPTH bytes that starts at
//     BASE_ADDR. The window accepts byte, half and word accesses at any
//     alignment.
//
// Ports
//   Clk          in   1            rising-edge clock
//   Rst          in   1            asynchronous, active-low reset
//   req          in   NUM_CLIENTS  per-client bus request (level)
//   grt          out  NUM_CLIENTS  one-hot registered grant
//   MemWriteBus  in   32           write data from the granted client
//   MemAddrBus   in   32           byte address from the granted client
//   WDMB         in   2            write mode: 0 none, 1 byte, 2 half, 3 word
//   RDMB         in   2            read mode, same encoding as WDMB
//   MemReadBus   out  32           combinational read data, zero-extended
//   BusErr       out  1            one-cycle pulse after an out-of-window access
// ---------------------------------------------------------------------------
module shared_bus_memory_port #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h8000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned HOLD_LIMIT  = 0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic [NUM_CLIENTS-1:0] grt,
  input  logic [31:0]            MemWriteBus,
  input  logic [31:0]            MemAddrBus,
  input  logic [1:0]             WDMB,
  input  logic [1:0]             RDMB,
  output logic [31:0]            MemReadBus,
  output logic                   BusErr
);

  localparam int NC    = int'(NUM_CLIENTS);
  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 16;

  // This is the value of the hold counter in the last cycle an owner may keep the bus.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_LIMIT == 0) ? '0 : CNT_W'(HOLD_LIMIT - 1);

  // The window bounds use 33 bits. A window that touches 32'hFFFF_FFFF
  // therefore cannot wrap the end-of-access sum.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(DEPTH) - 33'd1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  // -------------------------------------------------------------------------
  // Access size / window helpers
  // -------------------------------------------------------------------------
  function automatic logic [2:0] mode_size(input logic [1:0] mode);
    case (mode)
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      2'd3:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // An access is in the window only when every byte it touches lies inside
  // the window. An access that straddles either edge is rejected as a whole.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [1:0]  mode);
    logic [32:0] last;
    last = {1'b0, addr} + {30'b0, mode_size(mode)} - 33'd1;
    return (mode != 2'd0) && ({1'b0, addr} >= WIN_LO) && (last <= WIN_HI);
  endfunction

  // -------------------------------------------------------------------------
  // Arbiter state
  // -------------------------------------------------------------------------
  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic [CNT_W-1:0]         hold_q, hold_d;
  logic [NUM_CLIENTS-1:0]   grt_d;

  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         cand;
  logic                     hold_hit;

  // The search starts at the round-robin pointer and wraps. The first active
  // request it finds wins.
  // NOTE: every signal driven in always_comb gets a default value before any
  // branch. A missed path would otherwise infer a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NC; i++) begin
      cand = IDX_W'((int'(rr_q) + i) % NC);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign hold_hit = (HOLD_LIMIT != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    grt_d   = grt;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          hold_d  = '0;
          grt_d   = NUM_CLIENTS'(1) << pick_idx;
        end
      end
      GRANT: begin
        hold_d = hold_q + CNT_W'(1);
        // The access in this cycle still completes. Only the grant is
        // withdrawn, and that happens at the coming edge.
        if (!req[owner_q] || hold_hit) begin
          state_d = TURN;
          grt_d   = '0;
          rr_d    = (owner_q == IDX_W'(NC - 1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
      TURN: begin
        // This is the dead cycle for bus turnaround. Arbitration resumes from IDLE.
        state_d = IDLE;
        grt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        grt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. With blocking
  // assignments, every flop would see same-edge updates in evaluation order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      grt     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      grt     <= grt_d;
    end
  end

  // -------------------------------------------------------------------------
  // RAM window
  // -------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic          granted;
  logic          wr_ok;
  logic          rd_ok;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] off;
  logic [7:0]    rd_b0, rd_b1, rd_b2, rd_b3;

  assign granted = (grt != '0);
  assign wr_ok   = in_window(MemAddrBus, WDMB);
  assign rd_ok   = in_window(MemAddrBus, RDMB);
  assign wr_en   = granted && wr_ok;
  assign rd_en   = granted && rd_ok;

  // The window offset is meaningful only when the access is in the window.
  // In that case no byte index wraps, so the AW-bit arithmetic is exact.
  assign off = MemAddrBus[AW-1:0] - BASE_ADDR[AW-1:0];

  assign rd_b0 = mem[off];
  assign rd_b1 = mem[off + AW'(1)];
  assign rd_b2 = mem[off + AW'(2)];
  assign rd_b3 = mem[off + AW'(3)];

  // The read path is combinational from the array as it stood before this
  // edge. A read and write to the same address in one cycle therefore returns the old data.
  always_comb begin
    MemReadBus = '0;
    if (rd_en) begin
      case (RDMB)
        2'd1:    MemReadBus = {24'b0, rd_b0};
        2'd2:    MemReadBus = {16'b0, rd_b1, rd_b0};
        2'd3:    MemReadBus = {rd_b3, rd_b2, rd_b1, rd_b0};
        default: MemReadBus = '0;
      endcase
    end
  end

  // NOTE: the array has no reset. Clearing it would add a reset fan-out to
  // every storage bit, and the contents are allowed to survive reset.
  // Gating on Rst means a write in flight when reset asserts is dropped.
  always_ff @(posedge Clk) begin
    if (Rst && wr_en) begin
      mem[off] <= MemWriteBus[7:0];
      if (WDMB != 2'd1) begin
        mem[off + AW'(1)] <= MemWriteBus[15:8];
      end
      if (WDMB == 2'd3) begin
        mem[off + AW'(2)] <= MemWriteBus[23:16];
        mem[off + AW'(3)] <= MemWriteBus[31:24];
      end
    end
  end

  // An out-of-window access by the granted client raises a single-cycle
  // error flag. An access with no grant never flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      BusErr <= 1'b0;
    end else begin
      BusErr <= granted && (((WDMB != 2'd0) && !wr_ok) ||
                            ((RDMB != 2'd0) && !rd_ok));
    end
  end

endmodule

// File: tb/tb_shared_bus_memory_port.sv
// ---------------------------------------------------------------------------
// tb_shared_bus_memory_port
//
// Testbench for shared_bus_memory_port with two instances:
//   dut  - HOLD_LIMIT = 0. Covers arbitration, the RAM, errors and reset.
//   dut2 - HOLD_LIMIT = 4. Covers forced grant rotation.
// Both instances share the clock, reset and bus inputs. Read expectations
// come from a byte-array model and are queued before the read is sampled.
// ---------------------------------------------------------------------------
module tb_shared_bus_memory_port;

  localparam int          NC    = 4;
  localparam logic [31:0] BASE  = 32'h8000;
  localparam int          DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] req1 = '0;
  logic [NC-1:0] req2 = '0;
  logic [NC-1:0] grt1, grt2;
  logic [31:0]   wdata = '0;
  logic [31:0]   addr  = '0;
  logic [1:0]    wdmb  = '0;
  logic [1:0]    rdmb  = '0;
  logic [31:0]   rdata1, rdata2;
  logic          err1, err2;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mdl [DEPTH];
  bit          bench_granted = 1'b0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  shared_bus_memory_port #(
    .NUM_CLIENTS(NC), .BASE_ADDR(BASE), .DEPTH(DEPTH), .HOLD_LIMIT(0)
  ) dut (
    .Clk(clk), .Rst(rst_n), .req(req1), .grt(grt1),
    .MemWriteBus(wdata), .MemAddrBus(addr), .WDMB(wdmb), .RDMB(rdmb),
    .MemReadBus(rdata1), .BusErr(err1)
  );

  shared_bus_memory_port #(
    .NUM_CLIENTS(NC), .BASE_ADDR(BASE), .DEPTH(DEPTH), .HOLD_LIMIT(4)
  ) dut2 (
    .Clk(clk), .Rst(rst_n), .req(req2), .grt(grt2),
    .MemWriteBus(wdata), .MemAddrBus(addr), .WDMB(wdmb), .RDMB(rdmb),
    .MemReadBus(rdata2), .BusErr(err2)
  );

  // ---------------- model ----------------
  function automatic int sz(input logic [1:0] m);
    return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : (m == 2'd3) ? 4 : 0;
  endfunction

  function automatic bit in_win(input logic [31:0] a, input logic [1:0] m);
    longint unsigned lo, hi;
    lo = a;
    hi = lo + longint'(sz(m)) - 1;
    return (m != 2'd0) && (lo >= BASE) && (hi <= longint'(BASE) + DEPTH - 1);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    if (bench_granted && in_win(a, m))
      for (int k = 0; k < sz(m); k++) r[8*k +: 8] = mdl[int'(a - BASE) + k];
    return r;
  endfunction

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    addr = a; wdmb = m; wdata = d; rdmb = 2'd0;
    step();
    if (bench_granted && in_win(a, m))
      for (int k = 0; k < sz(m); k++) mdl[int'(a - BASE) + k] = d[8*k +: 8];
    wdmb = 2'd0;
  endtask

  task automatic acquire(input int c, output int lat);
    req1 = 4'b0001 << c;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (grt1 == (4'b0001 << c)) begin
        lat = i;
        break;
      end
    end
    bench_granted = (lat > 0);
  endtask

  task automatic release_bus(output int lat);
    req1 = '0; wdmb = 2'd0; rdmb = 2'd0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (grt1 == '0) begin
        lat = i;
        break;
      end
    end
    bench_granted = 1'b0;
    step();
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rdmb = 2'd3; addr = BASE;        // an ungranted read must still return 0
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (grt1 !== 4'b0000 || err1 !== 1'b0 || rdata1 !== 32'h0 || grt2 !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: grt=%b err=%b rd=%h grt2=%b, want 0000 0 00000000 0000",
                 i, grt1, err1, rdata1, grt2);
      end
    end
    rdmb = 2'd0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] ra [9] = '{32'h8004, 32'h8005, 32'h8004, 32'h8008, 32'h8011,
                            32'h8012, 32'h80FC, 32'h80FF, 32'h80FD};
    logic [1:0]  rm [9] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
    logic [31:0] got, exp;
    int lat;
    req1 = 4'b0001;
    @(negedge clk);
    vectors++;
    if (grt1 !== 4'b0000) begin
      miscompares++;
      $display("FAIL grant_early: grt=%b want 0000", grt1);
    end
    step();
    vectors++;
    if (grt1 !== 4'b0001) begin
      miscompares++;
      $display("FAIL grant_latency: grt=%b want 0001 one clock after req", grt1);
    end
    bench_granted = 1'b1;
    wr(32'h8004, 2'd3, 32'h0000000A);
    wr(32'h8008, 2'd1, 32'h00000000);
    wr(32'h8011, 2'd2, 32'h0000BEEF);
    wr(32'h80FC, 2'd3, 32'h12345678);
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_no_err: BusErr=%b want 0", err1);
    end
    step();
    for (int i = 0; i < 9; i++) begin
      addr = ra[i]; rdmb = rm[i]; wdmb = 2'd0;
      exp_q.push_back(model_read(ra[i], rm[i]));
      @(negedge clk);
      vectors++;
      got = rdata1;
      exp = exp_q.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic_read[%0d] @%h mode %0d: got %h want %h", i, ra[i], rm[i], got, exp);
      end
      step();
    end
    rdmb = 2'd0;
    release_bus(lat);
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("FAIL basic_release: grant drop after %0d clocks, want 1", lat);
    end
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_g [$];
    logic [NC-1:0] g, eg;
    int run_len = 0, gap = 0, owners = 0;
    bit finished = 1'b0;
    exp_g.push_back(4'b0010);
    exp_g.push_back(4'b1000);
    exp_g.push_back(4'b0010);
    req1 = 4'b1010;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      g = grt1;
      if (g != '0) begin
        if (run_len == 0) begin
          eg = exp_g.pop_front();
          vectors++;
          if (g !== eg) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: grt=%b want %b", owners, g, eg);
          end
          if (owners > 0) begin
            // TURN plus the IDLE arbitration cycle: grt low for two clocks.
            vectors++;
            if (gap != 2) begin
              miscompares++;
              $display("FAIL rr_gap[%0d]: %0d idle grant cycles, want 2", owners, gap);
            end
          end
          owners++;
        end
        run_len++;
        gap = 0;
        if (run_len == 2) req1 = req1 & ~g;
      end else begin
        if (run_len != 0) begin
          run_len = 0;
          if (owners == 3) begin
            finished = 1'b1;
            break;
          end
        end
        gap++;
        req1 = 4'b1010;
      end
    end
    req1 = '0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL rr_timeout: only %0d owners seen, want 3", owners);
    end
    repeat (3) step();
  endtask

  task automatic test_errors();
    logic [31:0] ra [5] = '{32'h80FC, 32'h80FE, 32'h8100, 32'h80FF, 32'h8000};
    logic [1:0]  rm [5] = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [31:0] got, exp;
    int lat;
    acquire(0, lat);
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("FAIL err_acquire: latency %0d want 1", lat);
    end
    wr(BASE + DEPTH - 2, 2'd3, 32'hDEADBEEF);   // straddles the window end
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b1) begin
      miscompares++;
      $display("FAIL err_wr_pulse: BusErr=%b want 1", err1);
    end
    step();
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL err_wr_once: BusErr=%b want 0", err1);
    end
    step();
    addr = 32'h7FFF; rdmb = 2'd1;
    exp_q.push_back(model_read(32'h7FFF, 2'd1));
    @(negedge clk);
    vectors++;
    got = rdata1;
    exp = exp_q.pop_front();
    if (got !== exp || err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL err_rd_below: rd=%h err=%b want %h 0", got, err1, exp);
    end
    step();
    rdmb = 2'd0;
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b1) begin
      miscompares++;
      $display("FAIL err_rd_pulse: BusErr=%b want 1", err1);
    end
    step();
    @(negedge clk);
    vectors++;
    if (err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL err_rd_once: BusErr=%b want 0", err1);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      addr = ra[i]; rdmb = rm[i];
      exp_q.push_back(model_read(ra[i], rm[i]));
      @(negedge clk);
      vectors++;
      got = rdata1;
      exp = exp_q.pop_front();
      if (got !== exp) begin
        miscompares++;
        $display("FAIL err_read[%0d] @%h mode %0d: got %h want %h", i, ra[i], rm[i], got, exp);
      end
      step();
    end
    rdmb = 2'd0;
    release_bus(lat);
    // Accesses with no grant: no write, no error, read returns 0.
    wr(32'h8004, 2'd3, 32'hFFFFFFFF);
    wr(32'h7000, 2'd3, 32'hFFFFFFFF);
    addr = 32'h8004; rdmb = 2'd3;
    exp_q.push_back(model_read(32'h8004, 2'd3));
    @(negedge clk);
    vectors++;
    got = rdata1;
    exp = exp_q.pop_front();
    if (got !== exp || err1 !== 1'b0) begin
      miscompares++;
      $display("FAIL ungranted: rd=%h err=%b want %h 0", got, err1, exp);
    end
    step();
    rdmb = 2'd0;
    acquire(0, lat);
    addr = 32'h8004; rdmb = 2'd3;
    exp_q.push_back(model_read(32'h8004, 2'd3));
    @(negedge clk);
    vectors++;
    got = rdata1;
    exp = exp_q.pop_front();
    if (got !== exp || lat != 1) begin
      miscompares++;
      $display("FAIL ungranted_wr_dropped: rd=%h lat=%0d want %h 1", got, lat, exp);
    end
    step();
    rdmb = 2'd0;
    release_bus(lat);
  endtask

  task automatic test_hold_limit();
    logic [NC-1:0] exp_g [$];
    logic [NC-1:0] g, eg;
    logic [31:0]   got, exp;
    int run_len = 0, gap = 0, owners = 0;
    bit finished = 1'b0, rd_pending;
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b0010);
    req2 = 4'b0011;
    for (int cyc = 0; cyc < 60; cyc++) begin
      step();
      wdmb = 2'd0; rdmb = 2'd0; rd_pending = 1'b0;
      g = grt2;
      if (g != '0) begin
        if (run_len == 0) begin
          eg = exp_g.pop_front();
          vectors++;
          if (g !== eg) begin
            miscompares++;
            $display("FAIL hold_order[%0d]: grt=%b want %b", owners, g, eg);
          end
          if (owners > 0) begin
            vectors++;
            if (gap != 2) begin
              miscompares++;
              $display("FAIL hold_gap[%0d]: %0d idle cycles, want 2", owners, gap);
            end
          end
          owners++;
        end
        run_len++;
        gap = 0;
        // A write in the last granted cycle still commits.
        if (owners == 1 && run_len == 4) begin
          addr = 32'h8020; wdata = 32'hCAFEF00D; wdmb = 2'd3;
        end
        if (owners == 2 && run_len == 1) begin
          addr = 32'h8020; rdmb = 2'd3;
          exp_q.push_back(32'hCAFEF00D);
          rd_pending = 1'b1;
        end
      end else begin
        if (run_len != 0) begin
          vectors++;
          if (run_len != 4) begin
            miscompares++;
            $display("FAIL hold_len[%0d]: held %0d cycles, want 4", owners, run_len);
          end
          run_len = 0;
          if (owners == 4) begin
            finished = 1'b1;
            break;
          end
        end
        gap++;
      end
      if (rd_pending) begin
        @(negedge clk);
        vectors++;
        got = rdata2;
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL hold_last_cycle_write: got %h want %h", got, exp);
        end
      end
    end
    req2 = '0; wdmb = 2'd0; rdmb = 2'd0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL hold_timeout: %0d owners seen, want 4", owners);
    end
    repeat (3) step();
  endtask

  task automatic test_rw_and_reset();
    logic [31:0] got, exp;
    int lat;
    acquire(0, lat);
    wr(32'h8030, 2'd1, 32'h00000012);
    // Same-cycle read and write: the read returns the pre-write byte.
    addr = 32'h8030; wdmb = 2'd1; wdata = 32'h00000055; rdmb = 2'd1;
    exp_q.push_back(model_read(32'h8030, 2'd1));
    @(negedge clk);
    vectors++;
    got = rdata1;
    exp = exp_q.pop_front();
    if (got !== exp || lat != 1) begin
      miscompares++;
      $display("FAIL rw_same_old: rd=%h lat=%0d want %h 1", got, lat, exp);
    end
    step();
    mdl[8'h30] = 8'h55;
    wdmb = 2'd0;
    exp_q.push_back(model_read(32'h8030, 2'd1));
    @(negedge clk);
    vectors++;
    got = rdata1;
    exp = exp_q.pop_front();
    if (got !== exp) begin
      miscompares++;
      $display("FAIL rw_same_new: rd=%h want %h", got, exp);
    end
    step();
    // Reset mid-grant with a word write in flight.
    rdmb = 2'd0; addr = 32'h8030; wdata = 32'h77777777; wdmb = 2'd3;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (grt1 !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async_grt: grt=%b want 0000", grt1);
    end
    @(posedge clk);
    @(negedge clk);
    wdmb = 2'd0; req1 = '0; bench_granted = 1'b0;
    rst_n = 1'b1;
    step();
    acquire(0, lat);
    addr = 32'h8030; rdmb = 2'd3;
    exp_q.push_back(model_read(32'h8030, 2'd1));   // only the byte 55 is modelled
    rdmb = 2'd1;
    @(negedge clk);
    vectors++;
    got = rdata1;
    exp = exp_q.pop_front();
    if (got !== exp || lat != 1) begin
      miscompares++;
      $display("FAIL reset_write_dropped: rd=%h lat=%0d want %h 1", got, lat, exp);
    end
    step();
    rdmb = 2'd0;
    release_bus(lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_errors();
    test_hold_limit();
    test_rw_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
